ring_grey_gen: RTL and testbench

RING_GREY_GEN -- requirements
Module: ring_grey_gen

---
 rtl/ring_grey_pkg.sv | 15 +
 rtl/ring_grey_pad.sv | 15 +
 rtl/ring_grey_prescale.sv | 20 ++
 rtl/ring_grey_gen.sv | 50 +++++
 tb/tb_ring_grey_gen.sv | 138 +++++++++++++
 5 files changed

// File: rtl/ring_grey_pkg.sv
// ring_grey_pkg: mode codes, prescaler width, seed and Gray-encode helpers
// Helpers work on 32-bit values; callers truncate to their own WIDTH.
package ring_grey_pkg;
  localparam logic [1:0] MODE_GRAY_UP   = 2'b00;
  localparam logic [1:0] MODE_GRAY_DOWN = 2'b01;
  localparam logic [1:0] MODE_JOHNSON   = 2'b10;
  localparam logic [1:0] MODE_ONEHOT    = 2'b11;
  localparam int PRE_W = 7;
  function automatic logic [31:0] seed(input logic [1:0] m);
    return m == MODE_ONEHOT ? 32'd1 : 32'd0;
  endfunction
  function automatic logic [31:0] gray_enc(input logic [31:0] v);
    return v ^ (v >> 1);
  endfunction
endpackage

// File: rtl/ring_grey_pad.sv
// ring_grey_pad: pad wrapper, io_in = {SEL, RST, CLK}, fixed WIDTH=8 generator
// Ports: io_in packed control pads, io_out 8-bit pattern, wrap pulse
module ring_grey_pad (
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       wrap
);
  ring_grey_gen #(.WIDTH(8)) u_gen (
    .CLK   (io_in[0]),
    .RST   (io_in[1]),
    .SEL   (io_in[7:2]),
    .io_out(io_out),
    .wrap  (wrap)
  );
endmodule

// File: rtl/ring_grey_prescale.sv
// ring_grey_prescale: free-running 7-bit prescaler with hold, clear and tick compare
// Ports: i_clk clock, i_rst sync reset, i_clr clear (mode change), i_hold freeze,
//        i_e prescale exponent, o_tick high when the low E bits of pre are all ones
module ring_grey_prescale
  import ring_grey_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_hold,
  input  logic [2:0] i_e,
  output logic       o_tick
);
  logic [PRE_W-1:0] r_pre, w_mask;
  assign w_mask = PRE_W'((8'd1 << i_e) - 8'd1);
  assign o_tick = (r_pre & w_mask) == w_mask;
  always_ff @(posedge i_clk)
    if (i_rst || i_clr) r_pre <= '0;
    else if (!i_hold) r_pre <= r_pre + 1'b1;
endmodule

// File: rtl/ring_grey_gen.sv
// ring_grey_gen: Gray up/down, Johnson and one-hot pattern generator with prescaler
// Ports: CLK clock, RST sync reset, SEL {E[2:0], hold, mode[1:0]},
//        io_out pattern (decoded from registered state), wrap one-cycle wrap pulse
module ring_grey_gen
  import ring_grey_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [5:0]       SEL,
  output logic [WIDTH-1:0] io_out,
  output logic             wrap
);
  logic [WIDTH-1:0] r_st, w_next;
  logic [1:0]       r_mode_q;
  logic             w_tick, w_mchg, w_step;
  assign w_mchg = SEL[1:0] != r_mode_q;
  assign w_step = w_tick && !w_mchg && !SEL[2];
  ring_grey_prescale u_pre (
    .i_clk (CLK),
    .i_rst (RST),
    .i_clr (w_mchg),
    .i_hold(SEL[2]),
    .i_e   (SEL[5:3]),
    .o_tick(w_tick)
  );
  always_comb
    w_next = r_mode_q == MODE_GRAY_UP   ? r_st + 1'b1 :
             r_mode_q == MODE_GRAY_DOWN ? r_st - 1'b1 :
             r_mode_q == MODE_JOHNSON   ? {r_st[WIDTH-2:0], ~r_st[WIDTH-1]} :
                                          {r_st[WIDTH-2:0], r_st[WIDTH-1]};
  // Both Gray modes keep a binary count and encode on the way out
  assign io_out = r_mode_q[1] ? r_st : WIDTH'(gray_enc(32'(r_st)));
  always_ff @(posedge CLK)
    if (RST) begin
      r_st     <= '0;
      r_mode_q <= MODE_GRAY_UP;
      wrap     <= 1'b0;
    end else if (w_mchg) begin
      r_mode_q <= SEL[1:0];
      r_st     <= WIDTH'(seed(SEL[1:0]));
      wrap     <= 1'b0;
    end else begin
      if (w_step) r_st <= w_next;
      // Gray down also flags the step out of the seed onto all-ones
      wrap <= w_step && (w_next == WIDTH'(seed(r_mode_q)) ||
                         (r_mode_q == MODE_GRAY_DOWN && &w_next));
    end
endmodule

// File: tb/tb_ring_grey_gen.sv
// tb_ring_grey_gen: step-count reference model, directed literal checks and random stimulus
module tb_ring_grey_gen;
  logic       clk = 1'b0, rst = 1'b1;
  logic [5:0] sel = '0;
  logic [3:0] dut_out;
  logic       dut_wrap;
  logic [7:0] pad_in, pad_out;
  logic       pad_wrap;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] up_seq[16] = '{1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
  logic [3:0] john_seq[8] = '{1, 3, 7, 15, 14, 12, 8, 0};
  logic [3:0] oh_seq[4] = '{2, 4, 8, 1};
  always #5 clk = ~clk;
  assign pad_in = {sel, rst, clk};
  ring_grey_gen #(.WIDTH(4)) dut (
    .CLK(clk), .RST(rst), .SEL(sel), .io_out(dut_out), .wrap(dut_wrap)
  );
  ring_grey_pad pad (.io_in(pad_in), .io_out(pad_out), .wrap(pad_wrap));
  // Model: mode, number of steps taken since the seed, prescale count
  logic [1:0] m_mode = '0;
  int         m_n = 0, m_pre = 0;
  bit         m_stepped = 0, m_valid = 0;
  always @(posedge clk)
    if (rst) begin
      m_mode <= '0; m_n <= 0; m_pre <= 0; m_stepped <= 0; m_valid <= 1;
    end else if (sel[1:0] != m_mode) begin
      m_mode <= sel[1:0]; m_n <= 0; m_pre <= 0; m_stepped <= 0;
    end else if (sel[2]) begin
      m_stepped <= 0;
    end else begin
      m_pre     <= (m_pre + 1) % 128;
      m_stepped <= (m_pre % (1 << sel[5:3])) == (1 << sel[5:3]) - 1;
      m_n       <= m_n + (((m_pre % (1 << sel[5:3])) == (1 << sel[5:3]) - 1) ? 1 : 0);
    end
  function automatic int exp_out(logic [1:0] m, int n, int w);
    int p = 1 << w;
    int k;
    case (m)
      2'd0: begin k = n % p; return k ^ (k >> 1); end
      2'd1: begin k = (p - n % p) % p; return k ^ (k >> 1); end
      2'd2: begin
        k = n % (2 * w);
        return k <= w ? (1 << k) - 1 : (p - 1) & ~((1 << (k - w)) - 1);
      end
      default: return 1 << (n % w);
    endcase
  endfunction
  function automatic int exp_wrap(logic [1:0] m, int n, int w);
    int p = (m == 2'd0 || m == 2'd1) ? (1 << w) : m == 2'd2 ? 2 * w : w;
    return (n % p == 0 || (m == 2'd1 && n % p == 1)) ? 1 : 0;
  endfunction
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (m_valid) begin
      chk("out4", int'(dut_out), exp_out(m_mode, m_n, 4));
      chk("wrap4", int'(dut_wrap), m_stepped ? exp_wrap(m_mode, m_n, 4) : 0);
      chk("out8", int'(pad_out), exp_out(m_mode, m_n, 8));
      chk("wrap8", int'(pad_wrap), m_stepped ? exp_wrap(m_mode, m_n, 8) : 0);
    end
  task automatic edge_chk(string name, int exp_o, int exp_w);
    @(posedge clk);
    #1;
    chk({name, "_out"}, int'(dut_out), exp_o);
    chk({name, "_wrap"}, int'(dut_wrap), exp_w);
  endtask
  task automatic reset_to(logic [5:0] s);
    rst = 1'b1;
    sel = s;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    sel = '0;
    @(posedge clk);
    #1;
    chk("reset_out", int'(dut_out), 0);
    chk("reset_wrap", int'(dut_wrap), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) edge_chk("gray_up", int'(up_seq[i]), i == 15 ? 1 : 0);
    reset_to(6'b000001);
    edge_chk("down_reload", 0, 0);
    edge_chk("down1", 8, 1);
    edge_chk("down2", 9, 0);
    edge_chk("down3", 11, 0);
    edge_chk("down4", 10, 0);
    repeat (12) @(posedge clk);
    #1;
    sel = 6'b000010;
    edge_chk("john_reload", 0, 0);
    for (int i = 0; i < 8; i++) edge_chk("john", int'(john_seq[i]), i == 7 ? 1 : 0);
    sel = 6'b000011;
    edge_chk("oh_reload", 1, 0);
    for (int i = 0; i < 4; i++) edge_chk("onehot", int'(oh_seq[i]), i == 3 ? 1 : 0);
    edge_chk("oh5", 2, 0);
    edge_chk("oh6", 4, 0);
    sel = 6'b000000;
    edge_chk("switch", 0, 0);
    edge_chk("after_switch", 1, 0);
    reset_to(6'b010000);
    for (int i = 1; i <= 12; i++) edge_chk("e2", i < 4 ? 0 : i < 8 ? 1 : i < 12 ? 3 : 2, 0);
    sel = 6'b010100;
    repeat (5) edge_chk("hold", 2, 0);
    sel = 6'b010000;
    repeat (3) edge_chk("resume", 2, 0);
    edge_chk("resume_step", 6, 0);
    reset_to(6'b000000);
    repeat (10) @(posedge clk);
    #1;
    chk("st_a", int'(dut_out), 15);
    rst = 1'b1;
    edge_chk("mid_reset", 0, 0);
    rst = 1'b0;
    edge_chk("restart1", 1, 0);
    edge_chk("restart2", 3, 0);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rst = $urandom_range(0, 299) == 0;
      if ($urandom_range(0, 59) == 0) sel[1:0] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0)
        sel[5:3] = $urandom_range(0, 9) < 8 ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      sel[2] = $urandom_range(0, 7) == 0;
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
